// File: rtl/flow_stack_if.sv
// Op/response handshake bundle for flow_stack: the op channel flows toward the
// block and the response channel flows back out of it.
interface flow_stack_if #(
  parameter int AW = 16
);
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op;
  logic [AW-1:0] op_addr;
  logic          cond_zero;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_taken;
  logic [AW-1:0] resp_addr;

  modport master (
    output op_valid, op, op_addr, cond_zero, resp_ready,
    input  op_ready, resp_valid, resp_taken, resp_addr
  );

  modport slave (
    input  op_valid, op, op_addr, cond_zero, resp_ready,
    output op_ready, resp_valid, resp_taken, resp_addr
  );
endinterface

// File: rtl/flow_stack.sv
// Control-flow helper: a call/return address stack plus an enable-mask stack
// for predicated execution, with a sticky error state that only CLEAR exits.
module flow_stack #(
  parameter int AW     = 16,
  parameter int CDEPTH = 4,
  parameter int EDEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  flow_stack_if.slave                  bus,
  output logic                         en,
  output logic [$clog2(CDEPTH+1)-1:0]  call_depth,
  output logic [$clog2(EDEPTH)-1:0]    en_depth,
  output logic                         err,
  output logic [2:0]                   err_code
);
  localparam int CDW = $clog2(CDEPTH + 1);
  localparam int EW  = $clog2(EDEPTH);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CALL   = 3'd1;
  localparam logic [2:0] OP_RET    = 3'd2;
  localparam logic [2:0] OP_PUSHEN = 3'd3;
  localparam logic [2:0] OP_POPEN  = 3'd4;
  localparam logic [2:0] OP_ALLEN  = 3'd5;
  localparam logic [2:0] OP_JUMPF  = 3'd6;
  localparam logic [2:0] OP_CLEAR  = 3'd7;

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       call_mem_q [CDEPTH];
  logic [AW-1:0]       call_mem_d [CDEPTH];
  logic [CDW-1:0]      call_depth_q, call_depth_d;
  logic [EDEPTH-1:0]   enstack_q, enstack_d;
  logic [EW-1:0]       en_depth_q, en_depth_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_taken_q, resp_taken_d;
  logic [AW-1:0]       resp_addr_q, resp_addr_d;

  logic                accept;
  logic [AW-1:0]       top_entry;
  logic [2:0]          fault;
  logic                jump_bit0;

  assign bus.op_ready   = !resp_valid_q || bus.resp_ready;
  assign accept         = bus.op_valid && bus.op_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_taken = resp_taken_q;
  assign bus.resp_addr  = resp_addr_q;
  assign en             = enstack_q[0];
  assign call_depth     = call_depth_q;
  assign en_depth       = en_depth_q;
  assign err            = (state_q == HALTED);
  assign err_code       = err_code_q;

  // Entry at index depth-1 is the top of the call stack.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < CDEPTH; i++) begin
      if (call_depth_q == CDW'(i + 1)) top_entry = call_mem_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    call_mem_d   = call_mem_q;
    call_depth_d = call_depth_q;
    enstack_d    = enstack_q;
    en_depth_d   = en_depth_q;
    err_code_d   = err_code_q;
    resp_valid_d = resp_valid_q && !bus.resp_ready;
    resp_taken_d = resp_taken_q;
    resp_addr_d  = resp_addr_q;
    fault        = 3'd0;
    jump_bit0    = bus.cond_zero ? 1'b0 : enstack_q[0];

    if (accept) begin
      if (bus.op == OP_CLEAR) begin
        state_d      = RUN;
        call_depth_d = '0;
        enstack_d    = '1;
        en_depth_d   = '0;
        err_code_d   = 3'd0;
      end else if (bus.op != OP_NOP && state_q == RUN) begin
        resp_valid_d = 1'b1;
        resp_taken_d = 1'b0;
        resp_addr_d  = '0;
        case (bus.op)
          OP_CALL: begin
            if (enstack_q[0]) begin
              if (call_depth_q == CDW'(CDEPTH)) begin
                fault = 3'd1;
              end else begin
                for (int i = 0; i < CDEPTH; i++) begin
                  if (call_depth_q == CDW'(i)) call_mem_d[i] = bus.op_addr;
                end
                call_depth_d = call_depth_q + 1'b1;
                resp_taken_d = 1'b1;
                resp_addr_d  = bus.op_addr;
              end
            end
          end
          OP_RET: begin
            if (enstack_q[0]) begin
              if (call_depth_q == '0) begin
                fault = 3'd2;
              end else begin
                call_depth_d = call_depth_q - 1'b1;
                resp_taken_d = 1'b1;
                resp_addr_d  = top_entry;
              end
            end
          end
          OP_PUSHEN: begin
            if (en_depth_q == EW'(EDEPTH - 1)) begin
              fault = 3'd3;
            end else begin
              enstack_d  = {enstack_q[EDEPTH-2:0], enstack_q[0]};
              en_depth_d = en_depth_q + 1'b1;
            end
          end
          OP_POPEN: begin
            if (en_depth_q == '0) begin
              fault = 3'd4;
            end else begin
              enstack_d  = {1'b1, enstack_q[EDEPTH-1:1]};
              en_depth_d = en_depth_q - 1'b1;
            end
          end
          OP_ALLEN: enstack_d[0] = 1'b1;
          OP_JUMPF: begin
            enstack_d[0] = jump_bit0;
            resp_taken_d = !jump_bit0;
            resp_addr_d  = jump_bit0 ? '0 : bus.op_addr;
          end
          default: ;
        endcase
        if (fault != 3'd0) begin
          state_d    = HALTED;
          err_code_d = fault;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      for (int i = 0; i < CDEPTH; i++) call_mem_q[i] <= '0;
      call_depth_q <= '0;
      enstack_q    <= '1;
      en_depth_q   <= '0;
      err_code_q   <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      call_mem_q   <= call_mem_d;
      call_depth_q <= call_depth_d;
      enstack_q    <= enstack_d;
      en_depth_q   <= en_depth_d;
      err_code_q   <= err_code_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_addr_q  <= resp_addr_d;
    end
  end
endmodule

// File: tb/tb_flow_stack.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// queue-based reference model of the call and enable stacks.
module tb_flow_stack;
  localparam int AW     = 16;
  localparam int CDEPTH = 4;
  localparam int EDEPTH = 32;
  localparam int CDW    = $clog2(CDEPTH + 1);
  localparam int EW     = $clog2(EDEPTH);

  localparam logic [2:0] NOP = 3'd0, CALL = 3'd1, RET = 3'd2, PUSHEN = 3'd3;
  localparam logic [2:0] POPEN = 3'd4, ALLEN = 3'd5, JUMPF = 3'd6, CLEAR = 3'd7;

  logic           clk = 1'b0;
  logic           reset;
  logic           en, err;
  logic [CDW-1:0] call_depth;
  logic [EW-1:0]  en_depth;
  logic [2:0]     err_code;

  flow_stack_if #(.AW(AW)) bus ();

  flow_stack #(.AW(AW), .CDEPTH(CDEPTH), .EDEPTH(EDEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .en         (en),
    .call_depth (call_depth),
    .en_depth   (en_depth),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          cstack[$];
  bit          enb[$];
  int          edepth;
  bit          m_err;
  int          m_code;
  bit          m_valid;
  bit          m_taken;
  int          m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cstack.delete();
    enb.delete();
    for (int i = 0; i < EDEPTH; i++) enb.push_back(1'b1);
    edepth  = 0;
    m_err   = 1'b0;
    m_code  = 0;
    m_valid = 1'b0;
    m_taken = 1'b0;
    m_addr  = 0;
  endtask

  task automatic model_fault(input int code);
    m_err  = 1'b1;
    m_code = code;
  endtask

  task automatic model_step(input logic [2:0] o, input int a, input bit cz, input bit v, input bit rr);
    bit acc;
    acc = v && (!m_valid || rr);
    if (m_valid && rr) m_valid = 1'b0;
    if (!acc) return;
    if (o == CLEAR) begin
      cstack.delete();
      for (int i = 0; i < EDEPTH; i++) enb[i] = 1'b1;
      edepth = 0;
      m_err  = 1'b0;
      m_code = 0;
      return;
    end
    if (o == NOP || m_err) return;
    m_valid = 1'b1;
    m_taken = 1'b0;
    m_addr  = 0;
    case (o)
      CALL: if (enb[0]) begin
        if (cstack.size() == CDEPTH) model_fault(1);
        else begin cstack.push_back(a); m_taken = 1'b1; m_addr = a; end
      end
      RET: if (enb[0]) begin
        if (cstack.size() == 0) model_fault(2);
        else begin m_addr = cstack.pop_back(); m_taken = 1'b1; end
      end
      PUSHEN: begin
        if (edepth == EDEPTH - 1) model_fault(3);
        else begin enb.push_front(enb[0]); void'(enb.pop_back()); edepth++; end
      end
      POPEN: begin
        if (edepth == 0) model_fault(4);
        else begin void'(enb.pop_front()); enb.push_back(1'b1); edepth--; end
      end
      ALLEN: enb[0] = 1'b1;
      JUMPF: begin
        if (cz) enb[0] = 1'b0;
        if (!enb[0]) begin m_taken = 1'b1; m_addr = a; end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
    check("resp_taken", 32'(bus.resp_taken), 32'(m_taken));
    check("resp_addr",  32'(bus.resp_addr),  32'(m_addr));
    check("en",         32'(en),             32'(enb[0]));
    check("call_depth", 32'(call_depth),     32'(cstack.size()));
    check("en_depth",   32'(en_depth),       32'(edepth));
    check("err",        32'(err),            32'(m_err));
    check("err_code",   32'(err_code),       32'(m_code));
  endtask

  task automatic cyc(input logic [2:0] o, input int a, input bit cz, input bit v, input bit rr);
    bus.op        = o;
    bus.op_addr   = a[AW-1:0];
    bus.cond_zero = cz;
    bus.op_valid  = v;
    bus.resp_ready = rr;
    #1;
    check("op_ready", 32'(bus.op_ready), 32'(!m_valid || rr));
    model_step(o, a & 32'hFFFF, cz, v, rr);
    @(posedge clk);
    #1;
    check_all();
    $display("t=%0t op=%0d v=%0b rr=%0b addr=%h -> resp v=%0b t=%0b a=%h cd=%0d ed=%0d err=%0b/%0d",
             $time, o, v, rr, a[AW-1:0], bus.resp_valid, bus.resp_taken, bus.resp_addr,
             call_depth, en_depth, err, err_code);
  endtask

  task automatic do_reset(input bit with_op);
    reset          = 1'b0;
    bus.op         = CALL;
    bus.op_addr    = 16'h0BAD;
    bus.cond_zero  = 1'b0;
    bus.op_valid   = with_op;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    check("ready_after_reset", 32'(bus.op_ready), 32'd1);
    $display("t=%0t reset applied", $time);
  endtask

  initial begin
    reset          = 1'b0;
    bus.op         = NOP;
    bus.op_addr    = '0;
    bus.cond_zero  = 1'b0;
    bus.op_valid   = 1'b0;
    bus.resp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset(1'b0);

    // Nested call/return
    cyc(CALL, 32'h0100, 0, 1, 1);
    cyc(CALL, 32'h0200, 0, 1, 1);
    cyc(RET,  0,        0, 1, 1);
    check("ret1_addr", 32'(bus.resp_addr), 32'h0200);
    cyc(RET,  0,        0, 1, 1);
    check("ret2_addr", 32'(bus.resp_addr), 32'h0100);
    cyc(NOP,  0,        0, 0, 1);

    // Call stack overflow, halted ignore, CLEAR recovery
    for (int i = 0; i < 5; i++) cyc(CALL, 32'h1000 + i, 0, 1, 1);
    check("ovf_code", 32'(err_code), 32'd1);
    cyc(RET,   0, 0, 1, 1);
    cyc(CLEAR, 0, 0, 1, 1);
    check("clear_depth", 32'(call_depth), 32'd0);
    cyc(NOP,   0, 0, 0, 1);

    // JUMPF disables, CALL then suppressed, ALLEN restores
    cyc(JUMPF, 32'h0040, 1, 1, 1);
    check("jumpf_en", 32'(en), 32'd0);
    cyc(CALL,  32'h0300, 0, 1, 1);
    cyc(ALLEN, 0,        0, 1, 1);

    // Enable nesting and underflow
    cyc(PUSHEN, 0, 0, 1, 1);
    cyc(JUMPF,  32'h0050, 1, 1, 1);
    cyc(POPEN,  0, 0, 1, 1);
    cyc(POPEN,  0, 0, 1, 1);
    check("unf_code", 32'(err_code), 32'd4);
    cyc(CLEAR,  0, 0, 1, 1);

    // Backpressure: response must hold while consumer stalls
    cyc(CALL, 32'h0777, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(RET, 0, 0, 1, 0);
    cyc(RET, 0, 0, 1, 1);
    check("bp_ret_addr", 32'(bus.resp_addr), 32'h0777);
    cyc(NOP, 0, 0, 0, 1);

    // Enable stack overflow at EDEPTH-1
    for (int i = 0; i < EDEPTH; i++) cyc(PUSHEN, 0, 0, 1, 1);
    check("en_ovf_code", 32'(err_code), 32'd3);
    cyc(CLEAR, 0, 0, 1, 1);

    // Reset while busy
    for (int i = 0; i < 3; i++) cyc(CALL, 32'h2000 + i, 0, 1, 1);
    do_reset(1'b1);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        cyc(3'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flow_stack.md
FLOW_STACK -- requirements
Module: flow_stack

Interface
REQ-001 Parameter AW, default 16, address width of call-stack entries and op/resp addresses.
REQ-002 Parameter CDEPTH, default 4, call-stack entries (>=1).
REQ-003 Parameter EDEPTH, default 32, enable-stack bits (>=2).
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 op_valid  in  1  op request.
REQ-007 op_ready  out  1  block can accept op this cycle.
REQ-008 op  in  3  0 NOP, 1 CALL, 2 RET, 3 PUSHEN, 4 POPEN, 5 ALLEN, 6 JUMPF, 7 CLEAR.
REQ-009 op_addr  in  AW  target address for CALL (push value) and JUMPF.
REQ-010 cond_zero  in  1  JUMPF condition (tested register == 0).
REQ-011 en  out  1  current enable, enable-stack bit 0, combinational from state.
REQ-012 resp_valid  out  1  response available; held until resp_ready.
REQ-013 resp_ready  in  1  consumer accepts response.
REQ-014 resp_taken  out  1  control transfer taken.
REQ-015 resp_addr  out  AW  address to load into pc when taken.
REQ-016 call_depth  out  clog2(CDEPTH+1)  call entries held.
REQ-017 en_depth  out  clog2(EDEPTH)  PUSHENs outstanding.
REQ-018 err  out  1  sticky error flag.
REQ-019 err_code  out  3  1 call overflow, 2 call underflow, 3 en overflow, 4 en underflow, 0 none.

Function
REQ-020 Handshake: op accepted when op_valid && op_ready; op_ready = !resp_valid || resp_ready.
REQ-021 Every accepted op except NOP/CLEAR sets resp_valid on the next edge (1-cycle latency); NOP/CLEAR produce no response.
REQ-022 resp_valid clears on edge where resp_ready=1 unless a new op is accepted the same cycle, in which case it stays 1 with new data.
REQ-023 CALL: if en=1 and call_depth<CDEPTH, push op_addr, depth+1, resp taken=1 addr=op_addr; if en=0, no push, taken=0 addr=0.
REQ-024 RET: if en=1 and call_depth>0, pop, depth-1, taken=1 addr=popped entry; if en=0, no pop, taken=0 addr=0.
REQ-025 PUSHEN: enstack <= (enstack<<1) | enstack[0], en_depth+1; resp taken=0 addr=0.
REQ-026 POPEN: enstack <= (enstack>>1) with bit EDEPTH-1 filled with 1, en_depth-1; resp taken=0 addr=0.
REQ-027 ALLEN: enstack[0] <= 1, depth unchanged; resp taken=0 addr=0.
REQ-028 JUMPF: if cond_zero, enstack[0] <= 0; resp taken = !(new bit0), addr=op_addr when taken else 0.
REQ-029 Errors: CALL en=1 at full -> code 1; RET en=1 at empty -> code 2; PUSHEN at en_depth=EDEPTH-1 -> code 3; POPEN at en_depth=0 -> code 4.
REQ-030 Erroring op leaves both stacks and depths unchanged, sets err=1 and err_code, still returns resp taken=0 addr=0.
REQ-031 While err=1, all ops except CLEAR are accepted but ignored: no state change, no response; err_code holds first error.
REQ-032 CLEAR: empties call stack, enstack all ones, depths 0, err=0, err_code=0; pending resp_valid unaffected.
REQ-033 Error flag and code update on the same edge as the erroring op.
REQ-034 Two-state FSM: RUN (normal) and HALTED (err=1); RUN->HALTED on error, HALTED->RUN on CLEAR only.

Reset
REQ-035 reset=0 at posedge: call stack contents 0, call_depth=0, enstack all ones (en=1), en_depth=0, resp_valid=0, resp_taken=0, resp_addr=0, err=0, err_code=0, FSM RUN.
REQ-036 Reset asserted mid-operation discards any pending response and op in the same cycle; op_ready=1 first cycle after release.

Verification
REQ-037 CALL 0x0100, CALL 0x0200, RET, RET (resp_ready=1) -> resp (1,0x0100),(1,0x0200),(1,0x0200),(1,0x0100); call_depth 1,2,1,0.
REQ-038 CDEPTH=4: five CALLs -> fifth gives err=1 code 1, call_depth stays 4; next RET ignored, no resp; CLEAR -> err=0, depth 0.
REQ-039 JUMPF cond_zero=1 addr 0x0040 -> taken=1 addr 0x0040, en=0; CALL 0x0300 -> taken=0, depth 0; ALLEN -> en=1.
REQ-040 PUSHEN, JUMPF cond_zero=1, POPEN -> en 1,0,1, en_depth 1,1,0; POPEN again -> err code 4.
REQ-041 resp_ready=0 after CALL -> op_ready=0, resp held stable 5 cycles; resp_ready=1 with RET valid -> RET accepted same cycle, resp updates next edge.
REQ-042 reset=0 for one edge while resp_valid=1 and call_depth=3 -> all outputs at REQ-035 values next cycle.
